// File: rtl/logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit: op encodings and buffer depth.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_XNOR  = 3'b011;
  localparam logic [2:0] OP_ANDN  = 3'b100;
  localparam logic [2:0] OP_ORN   = 3'b101;
  localparam logic [2:0] OP_PASSA = 3'b110;
  localparam logic [2:0] OP_NOTA  = 3'b111;

  localparam int LU_DEPTH = 2;

endpackage

// File: rtl/logic_op_nbit.sv
// Purely combinational 8-way bitwise operator on WIDTH-bit operands.
module logic_op_nbit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_AND:   y_o = a_i & b_i;
      OP_OR:    y_o = a_i | b_i;
      OP_XOR:   y_o = a_i ^ b_i;
      OP_XNOR:  y_o = ~(a_i ^ b_i);
      OP_ANDN:  y_o = a_i & ~b_i;
      OP_ORN:   y_o = a_i | ~b_i;
      OP_PASSA: y_o = a_i;
      OP_NOTA:  y_o = ~a_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a 2-entry valid/ready result FIFO and an XOR checksum accumulator.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = LU_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic [WIDTH-1:0] acc_out
);

  if (DEPTH != LU_DEPTH || WIDTH < 1) begin : g_param_check
    $error("logic_unit_pipe: DEPTH must be 2 and WIDTH at least 1");
  end

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0]       count_q, count_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] result;
  logic             push, pop;

  logic_op_nbit #(.WIDTH(WIDTH)) u_op (
    .op_i (op),
    .a_i  (a),
    .b_i  (b),
    .y_o  (result)
  );

  assign in_ready  = (count_q != FULL) & ~rst;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Empty buffer presents zero so stale entries never leak onto out.
  assign out      = out_valid ? buf_q[head_q] : '0;
  assign out_zero = (out == '0);
  assign acc_out  = acc_q;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    acc_d   = acc_q;

    if (push) tail_d = ~tail_q;
    if (pop)  head_d = ~head_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Clear dominates, but a result folded in on the same cycle survives it.
    if (acc_clr)              acc_d = (push & acc_en) ? result : '0;
    else if (push & acc_en)   acc_d = acc_q ^ result;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      acc_q   <= acc_d;
    end
  end

  // NOTE: the two buffer entries are cleared on reset so the storage starts in a known state.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (push) begin
      buf_q[tail_q] <= result;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: truth-table reference model, decoupled output monitor.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         acc_en;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         out_zero;
  logic [W-1:0] acc_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] sb [$];
  int           model_count;
  logic [W-1:0] model_acc;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .DEPTH(LU_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_zero  (out_zero),
    .acc_out   (acc_out)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Each op is a 4-entry truth table indexed by {a_bit, b_bit}, applied bit by bit.
  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [3:0]   tt [8];
    logic [3:0]   row;
    logic [W-1:0] r;
    tt[0] = 4'b1000;  // AND
    tt[1] = 4'b1110;  // OR
    tt[2] = 4'b0110;  // XOR
    tt[3] = 4'b1001;  // XNOR
    tt[4] = 4'b0100;  // a & ~b
    tt[5] = 4'b1101;  // a | ~b
    tt[6] = 4'b1100;  // a
    tt[7] = 4'b0011;  // ~a
    row = tt[o];
    r = '0;
    for (int i = 0; i < W; i++) r[i] = row[{x[i], y[i]}];
    return r;
  endfunction

  // Monitor: whenever the DUT is about to hand over a result, it must match the oldest expected.
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h, expected no output at %0t", out, $time);
        end else begin
          exp = sb.pop_front();
          check("out_data", out, exp);
          check("out_zero", W'(out_zero), W'(exp == '0));
        end
      end
    end
  end

  // One clock of stimulus; the model decides from its own occupancy whether a push/pop happens.
  task automatic cyc(input bit v, input logic [2:0] o, input logic [W-1:0] aa,
                     input logic [W-1:0] bb, input bit ae, input bit ac, input bit ordy,
                     input bit r, output bit pushed);
    bit           exp_ready, popped;
    logic [W-1:0] res;
    in_valid  = v;
    op        = o;
    a         = aa;
    b         = bb;
    acc_en    = ae;
    acc_clr   = ac;
    out_ready = ordy;
    rst       = r;
    @(negedge clk);
    exp_ready = !r && (model_count != 2);
    check("in_ready", W'(in_ready), W'(exp_ready));
    check("out_valid", W'(out_valid), W'(model_count != 0));
    if (model_count == 0) begin
      check("empty_out", out, '0);
      check("empty_zero", W'(out_zero), W'(1));
    end
    pushed = v && exp_ready;
    popped = !r && ordy && (model_count != 0);
    res    = ref_op(o, aa, bb);
    if (r) begin
      model_count = 0;
      model_acc   = '0;
      sb.delete();
    end else begin
      if (pushed) sb.push_back(res);
      if (pushed && !popped) model_count++;
      else if (popped && !pushed) model_count--;
      if (ac) model_acc = (pushed && ae) ? res : '0;
      else if (pushed && ae) model_acc = model_acc ^ res;
    end
    @(posedge clk);
    #1;
    check("acc_out", acc_out, model_acc);
  endtask

  task automatic idle(input bit ordy);
    bit p;
    cyc(1'b0, OP_AND, '0, '0, 1'b0, 1'b0, ordy, 1'b0, p);
  endtask

  initial begin
    bit           p;
    logic [W-1:0] vals [3];
    rst = 1'b1; in_valid = 1'b0; op = OP_AND; a = '0; b = '0;
    acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    model_count = 0;
    model_acc   = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset cycle with a push attempt that must be dropped.
    cyc(1'b1, OP_PASSA, 16'hDEAD, '0, 1'b1, 1'b0, 1'b0, 1'b1, p);
    idle(1'b1);

    // First transaction: F0F0 ^ 0FF0 = FF00.
    cyc(1'b1, OP_XOR, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 1'b1, 1'b0, p);
    idle(1'b1);

    // All eight ops on fixed operands, back to back.
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 16'hA5C3, 16'h0F0F, 1'b0, 1'b0, 1'b1, 1'b0, p);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: fill to two, third is held until a pop frees space.
    for (int i = 1; i <= 3; i++) cyc(1'b1, OP_PASSA, W'(i), '0, 1'b0, 1'b0, 1'b0, 1'b0, p);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, OP_PASSA, W'(3), '0, 1'b0, 1'b0, 1'b1, 1'b0, p);
      if (p) break;
    end
    repeat (3) idle(1'b1);

    // Accumulator folding then clear-with-fold.
    vals[0] = 16'h00FF; vals[1] = 16'h0F0F; vals[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) cyc(1'b1, OP_PASSA, vals[i], '0, 1'b1, 1'b0, 1'b1, 1'b0, p);
    cyc(1'b1, OP_PASSA, 16'h1234, '0, 1'b1, 1'b1, 1'b1, 1'b0, p);
    cyc(1'b0, OP_AND, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, p);  // clear alone, acc_en ignored

    // Zero result, then the empty-buffer view.
    cyc(1'b1, OP_XOR, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, p);
    repeat (2) idle(1'b1);

    // Reset with two entries buffered and a non-zero accumulator.
    cyc(1'b1, OP_PASSA, 16'hAAAA, '0, 1'b1, 1'b0, 1'b0, 1'b0, p);
    cyc(1'b1, OP_PASSA, 16'h0101, '0, 1'b1, 1'b0, 1'b0, 1'b0, p);
    cyc(1'b1, OP_PASSA, 16'hBEEF, '0, 1'b1, 1'b0, 1'b0, 1'b1, p);
    idle(1'b1);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 500; i++) begin
      bit r;
      r = ($urandom_range(0, 63) == 0);
      cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
          !r && ($urandom_range(0, 3) != 0), r, p);
    end

    repeat (4) idle(1'b1);
    check("scoreboard_empty", W'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, buffered successor to the fixed 16-bit bitwise gate arrays. It performs one of eight bitwise operations on WIDTH-bit operands and returns results through a 2-entry output buffer with valid/ready handshakes. It also keeps a running XOR checksum accumulator, used for register-file and memory-stream parity checks. It sits beside the ALU, on the execute-stage side path.

Parameters:
WIDTH, 16, operand, result and accumulator width in bits (minimum 1).
DEPTH, 2, output buffer entries (fixed at 2; a parameter only so the package can check it).

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept this cycle
op  in  3  operation select (see Behaviour)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
acc_en  in  1  fold this transaction's result into accumulator
acc_clr  in  1  clear accumulator (independent of handshake)
out_valid  out  1  result available at head of buffer
out_ready  in  1  consumer takes head result
out  out  WIDTH  head result
out_zero  out  1  head result == 0
acc_out  out  WIDTH  accumulator value

Behaviour:
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 XNOR
  - 100 ANDN (a & ~b)
  - 101 ORN (a | ~b)
  - 110 PASSA (a)
  - 111 NOTA (~a)
- Result is computed combinationally from a, b and op at acceptance and stored in the buffer. The buffer does not store op.
- Transfers:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
- Buffer state is a count in 0..2, with head/tail pointers in 0..1 that wrap modulo 2. Results leave in strict FIFO order.
- in_ready = (count != 2) & ~rst.
- out_valid = (count != 0). out and out_zero reflect the head entry. When count==0, out = 0 and out_zero = 1.
- Latency: data pushed at edge N appears with out_valid=1 in the cycle after edge N. There is no combinational in->out path.
- Throughput is one transaction per cycle while the consumer keeps out_ready high.
- Simultaneous push & pop:
  - count 1: count stays 1, and the new entry becomes head after the pop.
  - count 0: out_valid is 0, so no pop occurs; count goes to 1.
  - count 2: no push is possible.
- Backpressure: with out_ready low, the buffer fills to 2, then in_ready drops to 0. Head data holds stable until popped.
- Accumulator update (acc register):
  - acc_clr & push & acc_en: acc <= result (clear wins, then this result folds in).
  - acc_clr alone: acc <= 0.
  - push & acc_en: acc <= acc ^ result.
  - Otherwise hold.
- acc_en is ignored when there is no push.
- acc_out is registered and updates the cycle after the triggering edge.
- Reset (synchronous, checked at clk edge):
  - count=0, pointers=0, acc=0, buffer contents=0.
  - Outputs: out_valid=0, out=0, out_zero=1, acc_out=0, in_ready=0 while rst is high.
  - Any in-flight buffered results are discarded. A push attempted in the same cycle as rst is dropped.
- Width rules: all ops are width-preserving; there are no carries and no sign handling.

Decomposition:
- Shared package logic_unit_pkg:
  - op encodings as named localparams (OP_AND..OP_NOTA)
  - LU_DEPTH = 2
- Sub-module logic_op_nbit (param WIDTH): a purely combinational 8-way bitwise op. It is reusable by the ALU and replaces the per-width xor/and/or gate-array modules.
- The top level holds the buffer, count/pointers, handshake and accumulator.

Test Plan:
- After reset, push a=16'hF0F0, b=16'h0FF0, op=XOR with out_ready=1 -> next cycle out_valid=1, out=16'hFF00, out_zero=0, in_ready=1.
- Sweep all 8 ops with a=16'hA5C3, b=16'h0F0F -> AND 0503, OR AF CF, XOR AACC, XNOR 5533, ANDN A0C0, ORN F5F3, PASSA A5C3, NOTA 5A3C.
- Hold out_ready=0 and push 3 back-to-back (PASSA of 1, 2, 3) -> in_ready falls after the 2nd accept; the 3rd is held until pop. Releasing out_ready gives out order 1, 2, 3 with no loss or duplicate.
- Apply acc_en on pushes with PASSA of 16'h00FF, 16'h0F0F, 16'hFFFF -> acc_out = 00FF, then 0FF0, then F00F. Then acc_clr with acc_en on a push of 16'h1234 -> acc_out = 1234.
- XOR a=b=16'h5555 -> out=0000, out_zero=1. With an empty buffer -> out=0, out_zero=1.
- Assert rst with 2 entries buffered and acc≠0 -> the next cycle has out_valid=0, acc_out=0, in_ready=0 during rst and 1 after. A push in the rst cycle is not observed.
